load_store_unit: RTL and testbench

- Memory-access stage between the datapath (EX result) and the word-wide data memory.
- Accepts byte, halfword and word loads/stores, and checks alignment and range.
- Performs read-modify-write for sub-word stores, because the data memory writes whole 32-bit words only.
- Returns sign- or zero-extended load data to the writeback path with a ready/done handshake.

---
 rtl/load_store_unit.sv | 132 +++++++++++++
 tb/tb_load_store_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage: byte/half/word loads and stores against a word-wide memory,
// with alignment/range checking and read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);
    // Handshake: a request is taken on a rising edge where req=1 and ready=1;
    // done pulses for one cycle with err and rdata valid, and ready returns next cycle.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_BYTES);

    logic [1:0]  state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic        err_q;

    logic        bad_req;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic        mem_active;

    assign bad_req = (size == 2'b11)
                   || (size == 2'b10 && addr[1:0] != 2'b00)
                   || (size == 2'b01 && addr[0])
                   || (addr >= ADDR_LIMIT);

    // Right-justify the addressed lane; halfword addresses are even so bits [15:0] hold it.
    assign shifted = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_val = mem_rdata;
        case (size_q)
            2'b00:   load_val = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        merged = word_q;
        case (size_q)
            2'b00: begin
                for (int k = 0; k < 4; k++) begin
                    if (addr_q[1:0] == 2'(k)) merged[8*k +: 8] = wdata_q[7:0];
                end
            end
            2'b01: begin
                if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            word_q  <= 32'h0;
            err_q   <= 1'b0;
            rdata   <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        uns_q   <= is_unsigned;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        err_q   <= bad_req;
                        if (bad_req)                    state <= S_RESP;
                        else if (we && size == 2'b10)   state <= S_WRITE;
                        else                            state <= S_READ;
                    end
                end
                S_READ: begin
                    word_q <= mem_rdata;
                    if (we_q) begin
                        state <= S_WRITE;
                    end else begin
                        rdata <= load_val;
                        state <= S_RESP;
                    end
                end
                S_WRITE: state <= S_RESP;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Enables are killed while reset is high so a reset landing in WRITE commits nothing.
    assign mem_active = (state == S_READ || state == S_WRITE) && !reset;
    assign mem_read   = (state == S_READ)  && !reset;
    assign mem_write  = (state == S_WRITE) && !reset;
    assign mem_addr   = mem_active ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata  = mem_write ? merged : 32'h0;

    assign ready = (state == S_IDLE);
    assign done  = (state == S_RESP);
    assign err   = (state == S_RESP) && err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written reset/throughput
// sequences, and randomized traffic checked against a byte-level memory model.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        is_unsigned = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready, done, err, mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [32];
  logic        tb_wr = 1'b0;
  logic [4:0]  tb_idx = 5'd0;
  logic [31:0] tb_data = 32'h0;

  logic [31:0] ref_mem [32];
  logic [31:0] ref_rdata;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(128)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
    .is_unsigned(is_unsigned), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[6:2]] <= mem_wdata;
    else if (tb_wr) mem[tb_idx] <= tb_data;
  end
  assign mem_rdata = mem[mem_addr[6:2]];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic preload(input logic [4:0] idx, input logic [31:0] data);
    @(negedge clk);
    tb_wr = 1'b1; tb_idx = idx; tb_data = data;
    @(posedge clk);
    #1 tb_wr = 1'b0;
  endtask

  // Issue one request and follow it to done, recording what the memory side saw.
  task automatic do_op(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic rdy0, output logic [31:0] got_rdata, output logic got_err,
                       output int lat, output int rd, output int wr,
                       output logic [31:0] seen_wdata, output logic [31:0] seen_addr,
                       output int both);
    @(negedge clk);
    rdy0 = ready;
    req = 1'b1; we = w; size = sz; is_unsigned = uns; addr = a; wdata = wd;
    @(posedge clk);
    lat = 0; rd = 0; wr = 0; both = 0;
    seen_wdata = 32'h0; seen_addr = 32'h0;
    got_rdata = 32'h0; got_err = 1'b0;
    while (lat < 10) begin
      @(negedge clk);
      req = 1'b0;
      lat++;
      if (mem_read) rd++;
      if (mem_write) begin wr++; seen_wdata = mem_wdata; end
      if (mem_read || mem_write) seen_addr = mem_addr;
      if (mem_read && mem_write) both++;
      if (done) begin
        got_rdata = rdata; got_err = err;
        break;
      end
    end
  endtask

  // Reference model: byte-granular memory arithmetic on ref_mem.
  task automatic model(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic e, output int lat, output logic [31:0] new_word);
    int nb;
    longint unsigned word, val, mask;
    nb = 1 << sz;
    e = (sz == 2'd3) || (a >= 32'd128) || ((a % nb) != 0);
    new_word = 32'h0;
    if (e) begin
      lat = 1;
    end else if (!w) begin
      word = longint'(ref_mem[a / 4]);
      val = word >> ((a % 4) * 8);
      mask = (64'd1 << (8 * nb)) - 1;
      val = val & mask;
      if (!uns && nb < 4 && ((val >> (8 * nb - 1)) & 1) == 1) val = val | (~mask);
      ref_rdata = val[31:0];
      lat = 2;
    end else begin
      logic [31:0] wv;
      wv = ref_mem[a / 4];
      for (int b = 0; b < nb; b++) begin
        int lane;
        lane = int'(a % 4) + b;
        wv[8 * lane +: 8] = wd[8 * b +: 8];
      end
      ref_mem[a / 4] = wv;
      new_word = wv;
      lat = (nb == 4) ? 2 : 3;
    end
  endtask

  typedef struct {
    logic        pre;
    logic [31:0] pre_word;
    logic        w;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic        rdy0, gerr, e;
    logic [31:0] grd, swd, sad, nw;
    int          lat, rd, wr, both, elat, accepts, dones, acc2, done1;
    logic [31:0] exp6 [2];

    vecs[0]  = '{1'b1, 32'h00000005, 1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 32'h00000005, 1'b0, 2, 32'h00000005};
    vecs[1]  = '{1'b1, 32'h11223344, 1'b1, 2'd0, 1'b0, 32'h09, 32'hAA, 32'h00000005, 1'b0, 3, 32'h1122AA44};
    vecs[2]  = '{1'b1, 32'h80FF0000, 1'b0, 2'd0, 1'b0, 32'h0B, 32'h0, 32'hFFFFFF80, 1'b0, 2, 32'h80FF0000};
    vecs[3]  = '{1'b0, 32'h0,        1'b0, 2'd0, 1'b1, 32'h0B, 32'h0, 32'h00000080, 1'b0, 2, 32'h80FF0000};
    vecs[4]  = '{1'b0, 32'h0,        1'b0, 2'd1, 1'b0, 32'h0A, 32'h0, 32'hFFFF80FF, 1'b0, 2, 32'h80FF0000};
    vecs[5]  = '{1'b0, 32'h0,        1'b0, 2'd1, 1'b1, 32'h0A, 32'h0, 32'h000080FF, 1'b0, 2, 32'h80FF0000};
    vecs[6]  = '{1'b0, 32'h0,        1'b0, 2'd1, 1'b0, 32'h05, 32'h0, 32'h000080FF, 1'b1, 1, 32'h0};
    vecs[7]  = '{1'b0, 32'h0,        1'b1, 2'd2, 1'b0, 32'h06, 32'h1, 32'h000080FF, 1'b1, 1, 32'h0};
    vecs[8]  = '{1'b0, 32'h0,        1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 32'h000080FF, 1'b1, 1, 32'h0};
    vecs[9]  = '{1'b0, 32'h0,        1'b1, 2'd2, 1'b0, 32'h80, 32'h1, 32'h000080FF, 1'b1, 1, 32'h0};
    vecs[10] = '{1'b1, 32'h11223344, 1'b1, 2'd1, 1'b0, 32'h02, 32'hBEEF, 32'h000080FF, 1'b0, 3, 32'hBEEF3344};
    vecs[11] = '{1'b1, 32'h00000000, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h000080FF, 1'b0, 2, 32'hDEADBEEF};
    vecs[12] = '{1'b1, 32'h12345678, 1'b0, 2'd2, 1'b0, 32'h7C, 32'h0, 32'h12345678, 1'b0, 2, 32'h12345678};
    vecs[13] = '{1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 32'h7F, 32'h0, 32'h00000012, 1'b0, 2, 32'h12345678};
    vecs[14] = '{1'b0, 32'h0,        1'b0, 2'd1, 1'b1, 32'h7E, 32'h0, 32'h00001234, 1'b0, 2, 32'h12345678};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_en", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].pre) preload(vecs[i].a[6:2], vecs[i].pre_word);
      do_op(vecs[i].w, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].wd,
            rdy0, grd, gerr, lat, rd, wr, swd, sad, both);
      check($sformatf("v%0d_ready", i), 32'(rdy0), 32'd1);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_err", i), 32'(gerr), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_rdata", i), grd, vecs[i].exp_rdata);
      check($sformatf("v%0d_reads", i), 32'(rd),
            32'(!vecs[i].exp_err && (!vecs[i].w || vecs[i].sz != 2'd2)));
      check($sformatf("v%0d_writes", i), 32'(wr), 32'(!vecs[i].exp_err && vecs[i].w));
      check($sformatf("v%0d_both", i), 32'(both), 32'd0);
      if (!vecs[i].exp_err) begin
        check($sformatf("v%0d_mem_addr", i), sad, {vecs[i].a[31:2], 2'b00});
        check($sformatf("v%0d_mem_word", i), mem[vecs[i].a[6:2]], vecs[i].exp_word);
        if (vecs[i].w) check($sformatf("v%0d_mem_wdata", i), swd, vecs[i].exp_word);
      end
    end

    // Reset landing in the WRITE cycle of a sub-word store
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd1; is_unsigned = 1'b0; addr = 32'h2; wdata = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("rstw_read_phase", 32'(mem_read), 32'd1);
    @(negedge clk);
    check("rstw_write_phase", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1 check("rstw_write_killed", 32'(mem_write), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("rstw_ready", 32'(ready), 32'd1);
    check("rstw_done", 32'(done), 32'd0);
    check("rstw_word", mem[0], 32'hBEEF3344);
    repeat (2) begin
      @(negedge clk);
      check("rstw_no_done", 32'(done), 32'd0);
    end

    // reset and req in the same cycle: request must not be taken
    @(negedge clk);
    reset = 1'b1; req = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h0;
    @(negedge clk);
    reset = 1'b0; req = 1'b0;
    check("rstreq_ready", 32'(ready), 32'd1);
    @(negedge clk);
    check("rstreq_idle", {30'd0, mem_read, ready}, 32'd1);

    // Back-to-back loads with req held high
    preload(5'd0, 32'h0A0A0A0A);
    preload(5'd1, 32'h0B0B0B0B);
    exp6[0] = 32'h0A0A0A0A; exp6[1] = 32'h0B0B0B0B;
    accepts = 0; dones = 0; acc2 = -1; done1 = -1;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h0;
    for (int c = 0; c < 12; c++) begin
      if (ready && req) begin
        accepts++;
        if (accepts == 2) acc2 = c;
      end
      if (done) begin
        if (dones < 2) check($sformatf("b2b_rdata%0d", dones), rdata, exp6[dones]);
        dones++;
        if (dones == 1) begin done1 = c; addr = 32'h4; end
        if (dones == 2) req = 1'b0;
      end
      @(negedge clk);
    end
    req = 1'b0;
    check("b2b_accepts", 32'(accepts), 32'd2);
    check("b2b_dones", 32'(dones), 32'd2);
    check("b2b_accept_after_done", 32'(acc2), 32'(done1 + 1));
    ref_rdata = 32'h0B0B0B0B;

    // Randomized traffic against the reference model
    for (int i = 0; i < 32; i++) begin
      logic [31:0] v;
      v = $urandom;
      ref_mem[i] = v;
      preload(5'(i), v);
    end
    for (int i = 0; i < 150; i++) begin
      logic        w, uns;
      logic [1:0]  sz;
      logic [31:0] a, wd;
      w = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 135));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 1);
      wd = $urandom;
      model(w, sz, uns, a, wd, e, elat, nw);
      do_op(w, sz, uns, a, wd, rdy0, grd, gerr, lat, rd, wr, swd, sad, both);
      check($sformatf("r%0d_lat", i), 32'(lat), 32'(elat));
      check($sformatf("r%0d_err", i), 32'(gerr), 32'(e));
      check($sformatf("r%0d_rdata", i), grd, ref_rdata);
      check($sformatf("r%0d_both", i), 32'(both), 32'd0);
      if (e) check($sformatf("r%0d_no_mem", i), 32'(rd + wr), 32'd0);
      else if (w) check($sformatf("r%0d_mem_wdata", i), swd, nw);
    end
    for (int i = 0; i < 32; i++) check($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
